// File: rtl/orb_feature_serializer_pkg.sv
// orb_stream_pkg: shared constants, FSM states and word packing for the ORB feature stream
// Used by the serializer and, later, by the host-side decoder.
package orb_stream_pkg;
    localparam logic [3:0] FEATURE_TAG = 4'hA;
    localparam logic [3:0] TRAILER_TAG = 4'hF;
    localparam int WORDS_PER_FEATURE = 10;
    typedef enum logic [1:0] {IDLE, FEAT, EOF} state_t;
    function automatic logic [31:0] pack_header(input logic [7:0] level, input logic [15:0] index);
        return {FEATURE_TAG, 4'h0, level, index};
    endfunction
    function automatic logic [31:0] pack_coord(input logic [15:0] x, input logic [15:0] y);
        return {y, x};
    endfunction
    function automatic logic [31:0] pack_trailer(input logic [15:0] count);
        return {TRAILER_TAG, 12'h000, count};
    endfunction
endpackage

// File: rtl/orb_feature_serializer_if.sv
// orb_feature_serializer_if: feature input handshake plus 32-bit word stream
// slave  = serializer view: takes in_*, drives out_*
// master = source/sink view: drives in_*, takes out_*
interface orb_feature_serializer_if #(
    parameter int COORD_BITS = 16,
    parameter int LEVEL_BITS = 4,
    parameter int DESC_BITS  = 256
);
    logic                  in_valid;
    logic [DESC_BITS-1:0]  in_descriptor;
    logic [COORD_BITS-1:0] in_feature_x;
    logic [COORD_BITS-1:0] in_feature_y;
    logic [LEVEL_BITS-1:0] in_level;
    logic                  out_input_ready;
    logic                  in_frame_end;
    logic [31:0]           out_word;
    logic                  out_valid;
    logic                  out_last;
    logic                  in_out_ready;
    modport slave (
        input  in_valid, in_descriptor, in_feature_x, in_feature_y, in_level, in_frame_end, in_out_ready,
        output out_input_ready, out_word, out_valid, out_last
    );
    modport master (
        output in_valid, in_descriptor, in_feature_x, in_feature_y, in_level, in_frame_end, in_out_ready,
        input  out_input_ready, out_word, out_valid, out_last
    );
endinterface

// File: rtl/orb_feature_serializer.sv
// orb_feature_serializer: serialises ORB features into a 32-bit valid/ready/last word stream
// clk     : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : slave side of orb_feature_serializer_if (feature in, word stream out, frame_end)
import orb_stream_pkg::*;
module orb_feature_serializer (
    input logic clk,
    input logic reset_n,
    orb_feature_serializer_if.slave bus
);
    state_t       state;
    logic [3:0]   beat;
    logic [15:0]  count;
    logic         eof_pending;
    logic         alive;
    logic [255:0] desc_q;
    logic [15:0]  x_q;
    logic [15:0]  y_q;
    logic [31:0]  word_q;
    logic         valid_q;
    logic         last_q;
    logic         last_beat;
    logic         hs;
    logic         accept;
    logic         eof_done;
    assign last_beat = state == FEAT && beat == 4'(WORDS_PER_FEATURE - 1);
    assign hs        = valid_q && bus.in_out_ready;
    // alive keeps ready low while reset is asserted and for the release cycle
    assign bus.out_input_ready = alive && !eof_pending && (state == IDLE || (last_beat && bus.in_out_ready));
    assign accept    = bus.in_valid && bus.out_input_ready;
    assign eof_done  = state == EOF && hs;
    assign bus.out_word  = word_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            beat        <= '0;
            count       <= '0;
            eof_pending <= 1'b0;
            alive       <= 1'b0;
            desc_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (eof_done) eof_pending <= 1'b0;
            else if (bus.in_frame_end) eof_pending <= 1'b1;
            if (eof_done) count <= '0;
            else if (accept && count != 16'hFFFF) count <= count + 16'd1;
            if (accept) begin
                state   <= FEAT;
                beat    <= '0;
                valid_q <= 1'b1;
                last_q  <= 1'b0;
                word_q  <= pack_header(8'(bus.in_level), count);
                desc_q  <= bus.in_descriptor;
                x_q     <= 16'(bus.in_feature_x);
                y_q     <= 16'(bus.in_feature_y);
            end else if (state == FEAT && hs) begin
                if (last_beat) begin
                    state   <= IDLE;
                    beat    <= '0;
                    valid_q <= 1'b0;
                    word_q  <= '0;
                end else begin
                    beat <= beat + 4'd1;
                    // descriptor words are taken LSW first by shifting the held copy down
                    if (beat == 4'd0) word_q <= pack_coord(x_q, y_q);
                    else begin
                        word_q <= desc_q[31:0];
                        desc_q <= desc_q >> 32;
                    end
                end
            end else if (state == IDLE && eof_pending) begin
                state   <= EOF;
                word_q  <= pack_trailer(count);
                valid_q <= 1'b1;
                last_q  <= 1'b1;
            end else if (eof_done) begin
                state   <= IDLE;
                word_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_orb_feature_serializer.sv
// tb_orb_feature_serializer: directed, table-driven bench for orb_feature_serializer
module tb_orb_feature_serializer;
    typedef struct {
        logic [15:0]  x;
        logic [15:0]  y;
        logic [3:0]   lvl;
        logic [255:0] desc;
        logic [31:0]  hdr;
        logic [31:0]  xy;
    } vec_t;
    typedef struct {
        logic [31:0] w;
        logic        l;
        int          c;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n;
    int   rdy_mode = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tab [3];
    beat_t got[$];
    beat_t exp_q[$];
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pl = 1'b0;
    logic [31:0] pw = '0;

    orb_feature_serializer_if #(.COORD_BITS(16), .LEVEL_BITS(4), .DESC_BITS(256)) bus();
    orb_feature_serializer dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // rdy_mode: 0 = always ready, 1 = pseudo-random, 2 = held off
    always @(posedge clk) begin
        #1;
        bus.in_out_ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    // collects handshaken words and verifies stability while stalled
    always @(negedge clk) begin
        if (!reset_n) pv = 1'b0;
        else begin
            if (pv && !pr) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_word", 64'(bus.out_word), 64'(pw));
                chk("stall_last", 64'(bus.out_last), 64'(pl));
            end
            if (bus.out_valid && bus.in_out_ready) got.push_back('{w: bus.out_word, l: bus.out_last, c: cyc});
            pv = bus.out_valid;
            pr = bus.in_out_ready;
            pw = bus.out_word;
            pl = bus.out_last;
        end
    end

    task automatic push_feature(input int i);
        logic [255:0] d;
        d = tab[i].desc;
        exp_q.push_back('{w: tab[i].hdr, l: 1'b0, c: 0});
        exp_q.push_back('{w: tab[i].xy, l: 1'b0, c: 0});
        for (int k = 0; k < 8; k++) exp_q.push_back('{w: d[32*k +: 32], l: 1'b0, c: 0});
    endtask

    task automatic push_trailer(input logic [31:0] w);
        exp_q.push_back('{w: w, l: 1'b1, c: 0});
    endtask

    // offers tab[i]; fe raises in_frame_end only in the accepting cycle
    task automatic send(input int i, input bit fe);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_descriptor = tab[i].desc;
        bus.in_feature_x  = tab[i].x;
        bus.in_feature_y  = tab[i].y;
        bus.in_level      = tab[i].lvl;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.out_input_ready;
            bus.in_frame_end = fe && acc;
            @(posedge clk);
            #1;
            bus.in_frame_end = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic pulse_fe();
        bus.in_frame_end = 1'b1;
        @(posedge clk);
        #1;
        bus.in_frame_end = 1'b0;
    endtask

    task automatic wait_stream(input string name);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (15) @(posedge clk);
        #1;
        chk({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            chk({name, "_word"}, 64'(got[k].w), 64'(exp_q[k].w));
            chk({name, "_last"}, 64'(got[k].l), 64'(exp_q[k].l));
        end
    endtask

    task automatic flush();
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        tab[0] = '{x: 16'd5, y: 16'd7, lvl: 4'd2, desc: {4{64'h0123_4567_89AB_CDEF}},
                   hdr: 32'hA002_0000, xy: 32'h0007_0005};
        tab[1] = '{x: 16'h1234, y: 16'hFFFF, lvl: 4'hF,
                   desc: {32'h8888_0007, 32'h7777_0006, 32'h6666_0005, 32'h5555_0004,
                          32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000},
                   hdr: 32'hA00F_0001, xy: 32'hFFFF_1234};
        tab[2] = '{x: 16'h0000, y: 16'h8001, lvl: 4'd0, desc: {8{32'hDEAD_BEEF}} ^ {256{1'b1}},
                   hdr: 32'hA000_0002, xy: 32'h8001_0000};
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_descriptor = '0;
        bus.in_feature_x = '0;
        bus.in_feature_y = '0;
        bus.in_level = '0;
        bus.in_frame_end = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        chk("rst_word", 64'(bus.out_word), 64'd0);
        chk("rst_ready", 64'(bus.out_input_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(bus.out_input_ready), 64'd1);

        // single feature, ready low through beats 0..8
        push_feature(0);
        send(0, 1'b0);
        for (int b = 0; b < 9; b++) begin
            @(negedge clk);
            chk("ready_low_beat", 64'(bus.out_input_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("ready_beat9", 64'(bus.out_input_ready), 64'd1);
        wait_stream("single");
        flush();

        // chained pair, frame end on the third accept of the frame
        push_feature(1);
        push_feature(2);
        push_trailer(32'hF000_0003);
        send(1, 1'b0);
        send(2, 1'b1);
        wait_stream("chain");
        chk("chain_gapless", 64'(got.size() >= 20 ? got[19].c - got[0].c : -1), 64'd19);
        flush();

        // random backpressure, new frame restarts index at 0
        rdy_mode = 1;
        push_feature(0);
        push_trailer(32'hF000_0001);
        send(0, 1'b0);
        pulse_fe();
        wait_stream("stall");
        flush();

        // two frame-end pulses 3 cycles apart, merged into one empty trailer
        rdy_mode = 2;
        @(posedge clk);
        #1;
        pulse_fe();
        repeat (2) @(posedge clk);
        #1;
        pulse_fe();
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
        push_trailer(32'hF000_0000);
        wait_stream("merge");
        flush();

        // reset at beat 4 abandons the feature
        send(1, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(bus.out_valid), 64'd0);
        chk("async_word", 64'(bus.out_word), 64'd0);
        chk("async_ready", 64'(bus.out_input_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        flush();
        @(posedge clk);
        #1;
        chk("ready_after_midrst", 64'(bus.out_input_ready), 64'd1);
        push_feature(0);
        send(0, 1'b0);
        wait_stream("post_rst");
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
